param_stack: RTL and testbench



---
 rtl/param_stack.sv | 110 +++++++++++
 tb/tb_param_stack.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/param_stack.sv
// Parametrised LIFO stack with registered top/next outputs.
// Optional sticky ovf/unf flags are built when PARAM_STACK_ERR_EN is defined.
module param_stack #(
   parameter  int WIDTH = 16,
   parameter  int DEPTH = 1000,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             norst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] top,
   output logic [WIDTH-1:0] next,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty,
   output logic             ovf,
   output logic             unf
);

   localparam int MEMD = (DEPTH > 2) ? DEPTH - 2 : 1;
   localparam int AW   = (MEMD > 1) ? $clog2(MEMD) : 1;

   logic [WIDTH-1:0] r_top;
   logic [WIDTH-1:0] r_next;
   logic [CW-1:0]    r_count;
   logic [WIDTH-1:0] r_mem [MEMD];

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_repl;
   logic             w_pop;
   logic [AW-1:0]    w_wr_idx;
   logic [AW-1:0]    w_rd_idx;
   logic [WIDTH-1:0] w_mem_rd;

   assign w_full   = (r_count == CW'(DEPTH));
   assign w_empty  = (r_count == '0);

   // push+pop on empty degrades to a plain push
   assign w_push   = push & ~w_full & (~pop | w_empty);
   assign w_repl   = push & pop & ~w_empty;
   assign w_pop    = pop & ~push & ~w_empty;

   assign w_wr_idx = AW'(r_count - CW'(2));
   assign w_rd_idx = AW'(r_count - CW'(3));
   assign w_mem_rd = r_mem[w_rd_idx];

   // top, next and count registers
   always_ff @(posedge clk) begin
      if (!norst) begin
         r_top   <= '0;
         r_next  <= '0;
         r_count <= '0;
      end else if (w_push) begin
         r_top   <= data;
         r_next  <= (r_count >= CW'(1)) ? r_top : '0;
         r_count <= r_count + CW'(1);
      end else if (w_repl) begin
         r_top   <= data;
      end else if (w_pop) begin
         r_top   <= (r_count >= CW'(2)) ? r_next : '0;
         r_next  <= (r_count >= CW'(3)) ? w_mem_rd : '0;
         r_count <= r_count - CW'(1);
      end
   end

   // spill the old next entry into the array below the two registers
   always_ff @(posedge clk) begin
      if (norst && w_push && (r_count >= CW'(2))) begin
         r_mem[w_wr_idx] <= r_next;
      end
   end

`ifdef PARAM_STACK_ERR_EN
   logic w_ovf_ev;
   logic w_unf_ev;
   logic r_ovf;
   logic r_unf;

   assign w_ovf_ev = push & ~pop & w_full;
   assign w_unf_ev = pop & ~push & w_empty;

   // sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (!norst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (w_ovf_ev) r_ovf <= 1'b1;
         if (w_unf_ev) r_unf <= 1'b1;
      end
   end

   assign ovf = r_ovf;
   assign unf = r_unf;
`else
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif

   assign top   = r_top;
   assign next  = r_next;
   assign count = r_count;
   assign full  = w_full;
   assign empty = w_empty;

endmodule

// File: tb/tb_param_stack.sv
// Scoreboard bench for param_stack (DEPTH = 4).
// Driver queues hand-computed expectations; a monitor checks each cycle.
module tb_param_stack;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);
`ifdef PARAM_STACK_ERR_EN
   localparam bit ERR = 1'b1;
`else
   localparam bit ERR = 1'b0;
`endif

   typedef struct packed {
      logic [WIDTH-1:0] top;
      logic [WIDTH-1:0] nxt;
      logic [CW-1:0]    cnt;
      logic             full;
      logic             empty;
      logic             ovf;
      logic             unf;
   } exp_t;

   logic             clk = 1'b0;
   logic             norst = 1'b0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [WIDTH-1:0] data = '0;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] next;
   logic [CW-1:0]    count;
   logic             full;
   logic             empty;
   logic             ovf;
   logic             unf;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .norst (norst),
      .push  (push),
      .pop   (pop),
      .data  (data),
      .top   (top),
      .next  (next),
      .count (count),
      .full  (full),
      .empty (empty),
      .ovf   (ovf),
      .unf   (unf)
   );

   always #5 clk = ~clk;

   // monitor: compare DUT state against the oldest queued expectation
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         exp_t a;
         e = exp_q.pop_front();
         a = '{top: top, nxt: next, cnt: count, full: full,
               empty: empty, ovf: ovf, unf: unf};
         n_vec++;
         if (a !== e) begin
            n_bad++;
            $display("FAIL vec%0d: got top=%h next=%h cnt=%0d f=%b e=%b o=%b u=%b, want top=%h next=%h cnt=%0d f=%b e=%b o=%b u=%b",
                     n_vec, a.top, a.nxt, a.cnt, a.full, a.empty, a.ovf, a.unf,
                     e.top, e.nxt, e.cnt, e.full, e.empty, e.ovf, e.unf);
         end
      end
   end

   task automatic step(input logic r, input logic p, input logic q,
                       input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] et,
                       input logic [WIDTH-1:0] en,
                       input int ec, input logic eo, input logic eu);
      exp_t e;
      @(negedge clk);
      norst = r;
      push  = p;
      pop   = q;
      data  = d;
      @(posedge clk);
      #1;
      e.top   = et;
      e.nxt   = en;
      e.cnt   = CW'(ec);
      e.full  = (ec == DEPTH);
      e.empty = (ec == 0);
      e.ovf   = eo & ERR;
      e.unf   = eu & ERR;
      exp_q.push_back(e);
   endtask

   initial begin
      // reset and idle
      step(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      step(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      step(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      // basic push / pop
      step(1, 1, 0, 16'h0011, 16'h0011, 16'h0000, 1, 0, 0);
      step(1, 1, 0, 16'h0022, 16'h0022, 16'h0011, 2, 0, 0);
      step(1, 1, 0, 16'h0033, 16'h0033, 16'h0022, 3, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0022, 16'h0011, 2, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0011, 16'h0000, 1, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      // fill, overflow, drain, underflow
      step(1, 1, 0, 16'h0001, 16'h0001, 16'h0000, 1, 0, 0);
      step(1, 1, 0, 16'h0002, 16'h0002, 16'h0001, 2, 0, 0);
      step(1, 1, 0, 16'h0003, 16'h0003, 16'h0002, 3, 0, 0);
      step(1, 1, 0, 16'h0004, 16'h0004, 16'h0003, 4, 0, 0);
      step(1, 1, 0, 16'h0005, 16'h0004, 16'h0003, 4, 1, 0);
      step(1, 0, 1, 16'h0000, 16'h0003, 16'h0002, 3, 1, 0);
      step(1, 0, 1, 16'h0000, 16'h0002, 16'h0001, 2, 1, 0);
      step(1, 0, 1, 16'h0000, 16'h0001, 16'h0000, 1, 1, 0);
      step(1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 0);
      step(1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 1, 1);
      // replace while full
      step(1, 1, 0, 16'h0001, 16'h0001, 16'h0000, 1, 1, 1);
      step(1, 1, 0, 16'h0002, 16'h0002, 16'h0001, 2, 1, 1);
      step(1, 1, 0, 16'h0003, 16'h0003, 16'h0002, 3, 1, 1);
      step(1, 1, 0, 16'h0004, 16'h0004, 16'h0003, 4, 1, 1);
      step(1, 1, 1, 16'h0009, 16'h0009, 16'h0003, 4, 1, 1);
      step(0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      // replace, then push+pop on empty
      step(1, 1, 0, 16'h000A, 16'h000A, 16'h0000, 1, 0, 0);
      step(1, 1, 0, 16'h000B, 16'h000B, 16'h000A, 2, 0, 0);
      step(1, 1, 1, 16'h000C, 16'h000C, 16'h000A, 2, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h000A, 16'h0000, 1, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 1, 16'h0007, 16'h0007, 16'h0000, 1, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0);
      // reset overrides push; stale data stays hidden
      step(1, 1, 0, 16'h0021, 16'h0021, 16'h0000, 1, 0, 0);
      step(1, 1, 0, 16'h0022, 16'h0022, 16'h0021, 2, 0, 0);
      step(1, 1, 0, 16'h0023, 16'h0023, 16'h0022, 3, 0, 0);
      step(1, 1, 0, 16'h0024, 16'h0024, 16'h0023, 4, 0, 0);
      step(0, 1, 0, 16'h0055, 16'h0000, 16'h0000, 0, 0, 0);
      step(1, 1, 0, 16'h0009, 16'h0009, 16'h0000, 1, 0, 0);
      step(1, 1, 0, 16'h0008, 16'h0008, 16'h0009, 2, 0, 0);
      step(1, 1, 0, 16'h0007, 16'h0007, 16'h0008, 3, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0008, 16'h0009, 2, 0, 0);
      step(1, 0, 1, 16'h0000, 16'h0009, 16'h0000, 1, 0, 0);
      step(1, 0, 0, 16'h0000, 16'h0009, 16'h0000, 1, 0, 0);
      // let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: %0d pending, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
